// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if
// Groups the LED pattern input and the PWM pin drive of the LED fader.
//   led_in  [3:0] : pattern from the LED rotator, bit i = channel i lit
//   led_out [3:0] : PWM-modulated LED pin drive (registered in the fader)
//   fading        : high while any channel is decaying
// master : the side producing the pattern and watching the pins
// slave  : the fader itself
interface led_pwm_fader_if;
  logic [3:0] led_in;
  logic [3:0] led_out;
  logic       fading;

  modport master (output led_in, input led_out, input fading);
  modport slave  (input led_in, output led_out, output fading);
endinterface

// File: rtl/led_pwm_fader.sv
// led_pwm_fader
// PWM output stage for the 4-bit rotating LED pattern. A lit channel is
// driven at full brightness; a channel that goes dark decays linearly by
// DECAY_STEP every DECAY_DIV clocks, leaving a fading trail.
// Ports:
//   clk_50Mhz : system clock, rising edge
//   RST       : asynchronous active-high reset, clears all state
//   bus       : led_pwm_fader_if.slave (led_in in, led_out / fading out)
// Parameters:
//   PWM_BITS   : PWM counter and brightness width, MAX = 2^PWM_BITS-1
//   DECAY_DIV  : clocks per decay tick (>= 2)
//   DECAY_STEP : brightness decrement per decay tick (1..MAX)
module led_pwm_fader #(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 390625,
  parameter int DECAY_STEP = 8
) (
  input logic            clk_50Mhz,
  input logic            RST,
  led_pwm_fader_if.slave bus
);

  localparam int                  DCNT_W    = $clog2(DECAY_DIV);
  localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);
  localparam logic [DCNT_W-1:0]   DCNT_LAST = DCNT_W'(DECAY_DIV - 1);

  logic [3:0]                led_in_p0;
  logic [DCNT_W-1:0]         dcnt;
  logic                      decay_tick;
  logic [3:0][PWM_BITS-1:0]  level_p1;
  logic [3:0][PWM_BITS-1:0]  level_nxt;
  logic [3:0]                level_nz_nxt;
  logic                      fading_nxt;
  logic                      fading_p1;
  logic [PWM_BITS-1:0]       pwm_cnt;
  logic [3:0][PWM_BITS-1:0]  cmp_p2;
  logic [3:0]                led_out_p3;

  // Saturating decrement: a level at or below one step goes straight to dark.
  function automatic logic [PWM_BITS-1:0] sat_decay(input logic [PWM_BITS-1:0] lv);
    return (lv > STEP) ? (lv - STEP) : '0;
  endfunction

  always_comb begin
    decay_tick   = (dcnt == DCNT_LAST);
    level_nxt    = level_p1;
    level_nz_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      // A lit input wins over a coincident decay tick.
      if (led_in_p0[i])
        level_nxt[i] = MAX;
      else if (decay_tick)
        level_nxt[i] = sat_decay(level_p1[i]);
      level_nz_nxt[i] = |level_nxt[i];
    end
    // Evaluated against the values level and led_in_p0 take on this edge,
    // so fading stays aligned with the registered level.
    fading_nxt = |(level_nz_nxt & ~bus.led_in);
  end

  always_ff @(posedge clk_50Mhz or posedge RST) begin
    if (RST) begin
      led_in_p0  <= '0;
      dcnt       <= '0;
      level_p1   <= '0;
      fading_p1  <= 1'b0;
      pwm_cnt    <= '0;
      cmp_p2     <= '0;
      led_out_p3 <= '0;
    end else begin
      // p0: input capture
      led_in_p0 <= bus.led_in;

      // Free-running decay divider, never restarted by input activity.
      dcnt <= decay_tick ? '0 : dcnt + DCNT_W'(1);

      // p1: brightness level per channel
      level_p1  <= level_nxt;
      fading_p1 <= fading_nxt;

      pwm_cnt <= pwm_cnt + PWM_BITS'(1);

      // p2: compare shadow, reloaded only at the end of a PWM period so a
      // level change never produces a partial pulse.
      if (pwm_cnt == MAX)
        cmp_p2 <= level_p1;

      // p3: pin drive
      for (int i = 0; i < 4; i++)
        led_out_p3[i] <= (pwm_cnt < cmp_p2[i]);
    end
  end

  assign bus.led_out = led_out_p3;
  assign bus.fading  = fading_p1;

endmodule

// File: tb/tb_led_pwm_fader.sv
module tb_led_pwm_fader;
  localparam int PB   = 4;
  localparam int DIV  = 4;
  localparam int STEP = 4;
  localparam int MAXV = 15;
  localparam int PER  = 16;
  localparam int NH   = 16384;

  logic clk = 1'b0;
  logic RST = 1'b1;

  led_pwm_fader_if bus_if();

  led_pwm_fader #(
    .PWM_BITS  (PB),
    .DECAY_DIV (DIV),
    .DECAY_STEP(STEP)
  ) dut (
    .clk_50Mhz(clk),
    .RST      (RST),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  led_out;
    logic        fading;
    logic [15:0] level;
    logic [15:0] cmp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model, indexed by edge number k since reset release.
  int         k = 0;
  logic [3:0] lq_h [NH];
  int         lvl_h[NH][4];
  int         last_set[4];

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Compare shadow holds the level seen just before the last multiple-of-16 edge.
  function automatic int m_cmp(input int ch, input int kk);
    int e;
    e = (kk / PER) * PER;
    return (e == 0) ? 0 : lvl_h[e-1][ch];
  endfunction

  always @(posedge clk) begin
    exp_t e;
    e = '0;
    if (RST) begin
      k = 0;
      lq_h[0] = '0;
      for (int i = 0; i < 4; i++) begin
        lvl_h[0][i] = 0;
        last_set[i] = -1;
      end
    end else begin
      k = k + 1;
      lq_h[k] = bus_if.led_in;
      for (int i = 0; i < 4; i++) begin
        int v;
        if (lq_h[k-1][i]) last_set[i] = k;
        if (last_set[i] < 0) v = 0;
        else v = MAXV - STEP * (k / DIV - last_set[i] / DIV);
        if (v < 0) v = 0;
        lvl_h[k][i] = v;
        e.led_out[i]    = (((k - 1) % PER) < m_cmp(i, k - 1));
        e.level[4*i+:4] = 4'(v);
        e.cmp[4*i+:4]   = 4'(m_cmp(i, k));
        if (v != 0 && !lq_h[k][i]) e.fading = 1'b1;
      end
    end
    sb.push_back(e);
  end

  logic [15:0] prev_cmp = '0;
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!RST) begin
        chk("led_out", int'(bus_if.led_out), int'(e.led_out));
        chk("fading",  int'(bus_if.fading),  int'(e.fading));
        chk("level",   int'(dut.level_p1),   int'(e.level));
        chk("cmp",     int'(dut.cmp_p2),     int'(e.cmp));
        if (dut.cmp_p2 != prev_cmp)
          chk("cmp_only_at_wrap", int'(dut.pwm_cnt), 0);
      end
    end
    prev_cmp = RST ? 16'h0 : dut.cmp_p2;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic async_reset_check(input string nm);
    bus_if.led_in = 4'($urandom);
    RST = 1'b1;
    #1;
    chk({nm, "_led_out"}, int'(bus_if.led_out), 0);
    chk({nm, "_fading"},  int'(bus_if.fading),  0);
    chk({nm, "_level"},   int'(dut.level_p1),   0);
    chk({nm, "_cmp"},     int'(dut.cmp_p2),     0);
    tick(3);
    bus_if.led_in = 4'b0000;
    RST = 1'b0;
  endtask

  initial begin
    logic [3:0] pat;
    bit         found;
    bus_if.led_in = 4'b0000;
    RST = 1'b1;
    tick(3);
    RST = 1'b0;
    tick(100);

    // Full on
    bus_if.led_in = 4'b0001;
    tick(64);
    async_reset_check("rst_async");

    // Fade of channel 0 to dark
    bus_if.led_in = 4'b0001;
    tick(40);
    bus_if.led_in = 4'b0000;
    tick(60);

    // Re-assert on a decay tick cycle
    bus_if.led_in = 4'b0001;
    tick(20);
    bus_if.led_in = 4'b0000;
    tick(5);
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      if (k % DIV == 2) found = 1'b1;
      else tick(1);
    end
    chk("align_tick", int'(found), 1);
    bus_if.led_in = 4'b0001;
    tick(1);
    bus_if.led_in = 4'b0000;
    tick(40);

    // Random patterns
    for (int s = 0; s < 60; s++) begin
      bus_if.led_in = 4'($urandom);
      tick($urandom_range(1, 40));
    end
    bus_if.led_in = 4'b0000;
    tick(80);

    // Rotation trail
    for (int r = 0; r < 3; r++) begin
      pat = 4'b0001;
      for (int s = 0; s < 4; s++) begin
        bus_if.led_in = pat;
        tick(8);
        pat = {pat[2:0], pat[3]};
      end
    end
    bus_if.led_in = 4'b0100;
    tick(8);
    bus_if.led_in = 4'b0000;

    // Reset mid-fade once channel 2 reaches 7
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (lvl_h[k][2] == 7) found = 1'b1;
      else tick(1);
    end
    chk("wait_level7", int'(found), 1);
    async_reset_check("rst_midfade");
    tick(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
